// File: rtl/dmem_access_ctrl.sv
// Load/store sequencer between the LSU and a single-port, byte-addressed, word-wide data memory.
// Misaligned H/W accesses become two word beats; load data is merged, extended and registered.
module dmem_access_ctrl #(
  parameter int ADDR_W           = 32,
  parameter int DATA_W           = 32,
  parameter int ALLOW_MISALIGNED = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {S_IDLE, S_BEAT1} state_t;

  state_t            r_state;
  logic              r_rdy;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_f3;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_hold;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic [DATA_W-1:0] r_resp_rdata;

  logic [1:0]        w_off;
  logic [1:0]        w_sh1;
  logic              w_legal;
  logic              w_mis;
  logic              w_err;
  logic              w_acc;
  logic              w_beat0;
  logic [DATA_W-1:0] w_lo;
  logic [DATA_W-1:0] w_merge;

  function automatic logic [3:0] lane_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] extend(input logic [2:0] f3, input logic [DATA_W-1:0] d);
    case (f3)
      3'b000:  return {{(DATA_W-8){d[7]}}, d[7:0]};
      3'b001:  return {{(DATA_W-16){d[15]}}, d[15:0]};
      3'b100:  return {{(DATA_W-8){1'b0}}, d[7:0]};
      3'b101:  return {{(DATA_W-16){1'b0}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  assign w_off   = req_addr[1:0];
  assign w_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                   (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
  assign w_mis   = ((req_funct3[1:0] == 2'b01) && (w_off == 2'd3)) ||
                   ((req_funct3[1:0] == 2'b10) && (w_off != 2'd0));
  assign w_err   = !w_legal || (w_mis && (ALLOW_MISALIGNED == 0));
  assign w_acc   = req_valid && req_ready;
  assign w_beat0 = w_acc && !w_err;

  // Second beat shifts by (4 - off) lanes; off is never 0 in BEAT1.
  assign w_sh1   = 2'd0 - r_addr[1:0];
  assign w_lo    = mem_rdata >> {w_off, 3'b000};
  assign w_merge = r_hold | (mem_rdata << {w_sh1, 3'b000});

  assign req_ready  = r_rdy && (r_state == S_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;

  always_comb begin
    mem_addr  = {req_addr[ADDR_W-1:2], 2'b00};
    mem_be    = w_beat0 ? (lane_mask(req_funct3[1:0]) << w_off) : 4'b0000;
    mem_wdata = req_wdata << {w_off, 3'b000};
    mem_we    = w_beat0 && req_we;
    if (r_state == S_BEAT1) begin
      mem_addr  = {r_addr[ADDR_W-1:2], 2'b00} + ADDR_W'(4);
      mem_be    = lane_mask(r_f3[1:0]) >> w_sh1;
      mem_wdata = r_wdata >> {w_sh1, 3'b000};
      mem_we    = r_we;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_rdy        <= 1'b0;
      r_addr       <= '0;
      r_f3         <= 3'b000;
      r_we         <= 1'b0;
      r_wdata      <= '0;
      r_hold       <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_rdy        <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_addr  <= req_addr;
            r_f3    <= req_funct3;
            r_we    <= req_we;
            r_wdata <= req_wdata;
            r_hold  <= w_lo;
            if (w_err) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
            end else if (w_mis) begin
              r_state <= S_BEAT1;
            end else begin
              r_resp_valid <= 1'b1;
              r_resp_rdata <= req_we ? '0 : extend(req_funct3, w_lo);
            end
          end
        end
        S_BEAT1: begin
          r_state      <= S_IDLE;
          r_resp_valid <= 1'b1;
          r_resp_rdata <= r_we ? '0 : extend(r_f3, w_merge);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: word memory model, response scoreboard with due cycles,
// and a second instance built with misaligned accesses rejected.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;

  logic        req_ready, resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  logic        req_ready_b, resp_valid_b, resp_err_b, mem_we_b;
  logic [31:0] resp_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
  logic [3:0]  mem_be_b;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] mem [0:63] = '{default: '0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mem_rdata   = mem[mem_addr[7:2]];
  assign mem_rdata_b = mem[mem_addr_b[7:2]];

  always @(posedge clk) begin
    if (mem_we)
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) mem[mem_addr[7:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
  end

  dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .ALLOW_MISALIGNED(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .ALLOW_MISALIGNED(0)) u_dut_strict (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_b),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_b), .resp_rdata(resp_rdata_b), .resp_err(resp_err_b),
    .mem_addr(mem_addr_b), .mem_we(mem_we_b), .mem_be(mem_be_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata_b)
  );

  // Called just after a posedge; returns at the following negedge with the request on the bus.
  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err,
                       input int extra, input bit push);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    if (push) q.push_back(exp_t'{exp_rd, exp_err, cyc + 1 + extra});
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL req_ready@%h: got %b, required 1", addr, req_ready);
    end
  endtask

  // Completes the handshake and scrambles the request bus so later beats must use latched copies.
  task automatic step();
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'hA5A5_A5A4;
    req_wdata  = 32'h5A5A_5A5A;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL resp_timeout: got %0d responses outstanding, required 0", q.size());
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({resp_valid, resp_err, req_ready, mem_we, mem_be, resp_rdata} !== 40'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got valid=%b err=%b rdy=%b we=%b be=%b rdata=%h, required all 0",
               resp_valid, resp_err, req_ready, mem_we, mem_be, resp_rdata);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL ready_before_edge: got %b, required 0", req_ready);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_after_edge: got %b, required 1", req_ready);
    end
  endtask

  task automatic test_aligned();
    drive(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 0, 1'b1);
    n_cmp++;
    if ({mem_addr, mem_be, mem_wdata, mem_we} !== {32'h10, 4'b1111, 32'hDEAD_BEEF, 1'b1}) begin
      n_bad++;
      $display("FAIL sw_beat: got addr=%h be=%b wd=%h we=%b, required 00000010 1111 deadbeef 1",
               mem_addr, mem_be, mem_wdata, mem_we);
    end
    step();
    drive(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 0, 1'b1);
    n_cmp++;
    if ({mem_we, mem_be} !== 5'b0_1111) begin
      n_bad++;
      $display("FAIL lw_beat: got we=%b be=%b, required 0 1111", mem_we, mem_be);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if ({mem_we, mem_be} !== 5'b0) begin
      n_bad++;
      $display("FAIL single_beat: got we=%b be=%b, required 0 0000", mem_we, mem_be);
    end
    wait_drain();
  endtask

  task automatic test_extend();
    drive(1'b1, 3'b010, 32'h20, 32'h80FF_7F01, 32'h0, 1'b0, 0, 1'b1);
    step();
    drive(1'b0, 3'b000, 32'h23, 32'h0, 32'hFFFF_FF80, 1'b0, 0, 1'b1);
    step();
    drive(1'b0, 3'b100, 32'h23, 32'h0, 32'h0000_0080, 1'b0, 0, 1'b1);
    step();
    drive(1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF_80FF, 1'b0, 0, 1'b1);
    step();
    drive(1'b0, 3'b101, 32'h22, 32'h0, 32'h0000_80FF, 1'b0, 0, 1'b1);
    step();
    drive(1'b0, 3'b001, 32'h21, 32'h0, 32'hFFFF_FF7F, 1'b0, 0, 1'b1);
    n_cmp++;
    if (mem_be !== 4'b0110) begin
      n_bad++;
      $display("FAIL lh_off1_be: got %b, required 0110", mem_be);
    end
    step();
    drive(1'b0, 3'b000, 32'h20, 32'h0, 32'h0000_0001, 1'b0, 0, 1'b1);
    step();
    wait_drain();
  endtask

  task automatic test_misaligned();
    drive(1'b1, 3'b010, 32'h31, 32'h1122_3344, 32'h0, 1'b0, 1, 1'b1);
    n_cmp++;
    if ({mem_addr, mem_be, mem_wdata, mem_we} !== {32'h30, 4'b1110, 32'h2233_4400, 1'b1}) begin
      n_bad++;
      $display("FAIL sw31_beat0: got addr=%h be=%b wd=%h we=%b, required 00000030 1110 22334400 1",
               mem_addr, mem_be, mem_wdata, mem_we);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if ({mem_addr, mem_be, mem_wdata, mem_we} !== {32'h34, 4'b0001, 32'h0000_0011, 1'b1}) begin
      n_bad++;
      $display("FAIL sw31_beat1: got addr=%h be=%b wd=%h we=%b, required 00000034 0001 00000011 1",
               mem_addr, mem_be, mem_wdata, mem_we);
    end
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL ready_in_beat1: got %b, required 0", req_ready);
    end
    wait_drain();
    drive(1'b0, 3'b010, 32'h31, 32'h0, 32'h1122_3344, 1'b0, 1, 1'b1);
    step();
    wait_drain();
    drive(1'b1, 3'b001, 32'h43, 32'h0000_ABCD, 32'h0, 1'b0, 1, 1'b1);
    n_cmp++;
    if ({mem_addr, mem_be, mem_wdata} !== {32'h40, 4'b1000, 32'hCD00_0000}) begin
      n_bad++;
      $display("FAIL sh43_beat0: got addr=%h be=%b wd=%h, required 00000040 1000 cd000000",
               mem_addr, mem_be, mem_wdata);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if ({mem_addr, mem_be, mem_wdata[7:0]} !== {32'h44, 4'b0001, 8'hAB}) begin
      n_bad++;
      $display("FAIL sh43_beat1: got addr=%h be=%b wd=%h, required 00000044 0001 ......ab",
               mem_addr, mem_be, mem_wdata);
    end
    wait_drain();
    drive(1'b0, 3'b101, 32'h43, 32'h0, 32'h0000_ABCD, 1'b0, 1, 1'b1);
    step();
    wait_drain();
    drive(1'b0, 3'b001, 32'h43, 32'h0, 32'hFFFF_ABCD, 1'b0, 1, 1'b1);
    step();
    wait_drain();
  endtask

  task automatic test_errors();
    drive(1'b0, 3'b001, 32'h03, 32'h0, 32'h0, 1'b0, 1, 1'b1);
    n_cmp++;
    if ({mem_we_b, mem_be_b} !== 5'b0) begin
      n_bad++;
      $display("FAIL strict_no_beat: got we=%b be=%b, required 0 0000", mem_we_b, mem_be_b);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if ({resp_valid_b, resp_err_b, resp_rdata_b} !== {1'b1, 1'b1, 32'h0}) begin
      n_bad++;
      $display("FAIL strict_resp: got valid=%b err=%b rdata=%h, required 1 1 00000000",
               resp_valid_b, resp_err_b, resp_rdata_b);
    end
    wait_drain();
    drive(1'b1, 3'b011, 32'h08, 32'hFFFF_FFFF, 32'h0, 1'b1, 0, 1'b1);
    n_cmp++;
    if ({mem_we, mem_be, mem_we_b, mem_be_b} !== 10'b0) begin
      n_bad++;
      $display("FAIL illegal_no_beat: got we=%b be=%b we_b=%b be_b=%b, required all 0",
               mem_we, mem_be, mem_we_b, mem_be_b);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if ({resp_valid_b, resp_err_b, resp_rdata_b} !== {1'b1, 1'b1, 32'h0}) begin
      n_bad++;
      $display("FAIL strict_illegal_resp: got valid=%b err=%b rdata=%h, required 1 1 00000000",
               resp_valid_b, resp_err_b, resp_rdata_b);
    end
    wait_drain();
  endtask

  task automatic test_wrap();
    drive(1'b1, 3'b010, 32'hFFFF_FFFE, 32'hCAFE_F00D, 32'h0, 1'b0, 1, 1'b1);
    n_cmp++;
    if ({mem_addr, mem_be, mem_wdata} !== {32'hFFFF_FFFC, 4'b1100, 32'hF00D_0000}) begin
      n_bad++;
      $display("FAIL wrap_beat0: got addr=%h be=%b wd=%h, required fffffffc 1100 f00d0000",
               mem_addr, mem_be, mem_wdata);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if ({mem_addr, mem_be, mem_wdata, mem_we} !== {32'h0, 4'b0011, 32'h0000_CAFE, 1'b1}) begin
      n_bad++;
      $display("FAIL wrap_beat1: got addr=%h be=%b wd=%h we=%b, required 00000000 0011 0000cafe 1",
               mem_addr, mem_be, mem_wdata, mem_we);
    end
    wait_drain();
  endtask

  task automatic test_reset_beat1();
    drive(1'b1, 3'b010, 32'h51, 32'h5566_7788, 32'h0, 1'b0, 1, 1'b0);
    step();
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({mem_we, mem_be, req_ready, resp_valid} !== 7'b0) begin
      n_bad++;
      $display("FAIL rst_in_beat1: got we=%b be=%b rdy=%b valid=%b, required all 0",
               mem_we, mem_be, req_ready, resp_valid);
    end
    n_cmp++;
    if ({mem[20], mem[21]} !== {32'h6677_8800, 32'h0}) begin
      n_bad++;
      $display("FAIL rst_commit: got w50=%h w54=%h, required 66778800 00000000", mem[20], mem[21]);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_release_ready: got %b, required 0", req_ready);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_recover_ready: got %b, required 1", req_ready);
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    drive(1'b0, 3'b010, 32'h50, 32'h0, 32'h6677_8800, 1'b0, 0, 1'b1);
    step();
    wait_drain();
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    fork
      forever begin
        @(negedge clk);
        if (resp_valid === 1'b1) begin
          n_cmp++;
          if (q.size() == 0) begin
            n_bad++;
            $display("FAIL resp_unexpected: got rdata=%h err=%b at cycle %0d, required no response",
                     resp_rdata, resp_err, cyc);
          end else begin
            mon_e = q.pop_front();
            if (resp_rdata !== mon_e.rdata || resp_err !== mon_e.err || cyc !== mon_e.due) begin
              n_bad++;
              $display("FAIL resp: got rdata=%h err=%b cycle=%0d, required rdata=%h err=%b cycle=%0d",
                       resp_rdata, resp_err, cyc, mon_e.rdata, mon_e.err, mon_e.due);
            end
          end
        end
      end
    join_none
    test_reset();
    test_aligned();
    test_extend();
    test_misaligned();
    test_errors();
    test_wrap();
    test_reset_beat1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
